// File: rtl/adc_avg_pkg.sv
// Shared types and width helpers for the windowed ADC averager.
// Widths are derived here so the top and the channel datapath always agree.
package adc_avg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  function automatic int acc_w(input int adc_w, input int log2_samps);
    return adc_w + log2_samps;
  endfunction

  function automatic int out_w(input int adc_w, input int frac_bits);
    return adc_w + frac_bits;
  endfunction

  function automatic int shift_s(input int log2_samps, input int frac_bits);
    return log2_samps - frac_bits;
  endfunction

  function automatic bit params_ok(input int adc_w, input int num_ch,
                                   input int log2_samps, input int frac_bits);
    return (adc_w >= 2) && (num_ch >= 1) && (log2_samps >= 1) &&
           (log2_samps <= 16) && (frac_bits >= 0) && (frac_bits <= log2_samps);
  endfunction

endpackage

// File: rtl/adc_avg_channel.sv
// One channel: signed accumulator plus round-half-up shift to the output width.
// The mean register only loads on the last accepted sample of a window.
module adc_avg_channel
  import adc_avg_pkg::*;
#(
  parameter int ADC_WIDTH  = 12,
  parameter int LOG2_SAMPS = 10,
  parameter int FRAC_BITS  = 1
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           i_clear,
  input  logic                           i_add_en,
  input  logic                           i_last,
  input  logic [ADC_WIDTH-1:0]           i_sample,
  output logic [ADC_WIDTH+FRAC_BITS-1:0] o_mean
);

  localparam int AW = acc_w(ADC_WIDTH, LOG2_SAMPS);
  localparam int OW = out_w(ADC_WIDTH, FRAC_BITS);
  localparam int S  = shift_s(LOG2_SAMPS, FRAC_BITS);

  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_sample_ext;
  logic signed [AW-1:0] w_sum;
  logic signed [OW-1:0] w_round;
  logic signed [OW-1:0] r_mean;

  assign w_sample_ext = {{LOG2_SAMPS{i_sample[ADC_WIDTH-1]}}, i_sample};
  assign w_sum        = r_acc + w_sample_ext;

  generate
    if (S > 0) begin : g_round
      // One guard bit keeps the rounding bias from wrapping the full-scale sum.
      localparam logic signed [AW:0] HALF = (AW+1)'(1) <<< (S - 1);
      logic signed [AW:0] w_sum_ext;
      assign w_sum_ext = {w_sum[AW-1], w_sum};
      assign w_round   = OW'((w_sum_ext + HALF) >>> S);
    end else begin : g_pass
      assign w_round = w_sum;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc  <= '0;
      r_mean <= '0;
    end else begin
      if (i_clear)       r_acc <= '0;
      else if (i_add_en) r_acc <= i_last ? '0 : w_sum;
      if (i_add_en && i_last && !i_clear) r_mean <= w_round;
    end
  end

  assign o_mean = r_mean;

endmodule

// File: rtl/adc_window_average.sv
// Multi-channel windowed averager: shared IDLE/ACC control, sample counter and
// DONE/BUSY, with one accumulator datapath per channel.
module adc_window_average
  import adc_avg_pkg::*;
#(
  parameter int ADC_WIDTH  = 12,
  parameter int NUM_CH     = 2,
  parameter int LOG2_SAMPS = 10,
  parameter int FRAC_BITS  = 1
) (
  input  logic                                    CLK,
  input  logic                                    RST_N,
  input  logic [NUM_CH*ADC_WIDTH-1:0]             DATA_IN,
  input  logic                                    DATA_VALID,
  input  logic                                    START,
  input  logic                                    STOP,
  input  logic                                    MODE_CONT,
  output logic                                    BUSY,
  output logic                                    DONE,
  output logic [NUM_CH*(ADC_WIDTH+FRAC_BITS)-1:0] DATA_OUT
);

  localparam int OW = out_w(ADC_WIDTH, FRAC_BITS);

  generate
    if (!params_ok(ADC_WIDTH, NUM_CH, LOG2_SAMPS, FRAC_BITS)) begin : g_bad_params
      $error("adc_window_average: illegal parameter combination");
    end
  endgenerate

  state_e                            r_state;
  state_e                            w_state_nxt;
  logic [LOG2_SAMPS-1:0]             r_cnt;
  logic                              r_done;
  logic                              w_clear;
  logic                              w_add_en;
  logic                              w_last;
  logic [NUM_CH-1:0][ADC_WIDTH-1:0]  w_samples;
  logic [NUM_CH-1:0][OW-1:0]         w_means;

  // STOP dominates everything in ACC, including a final sample in that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b1;
    w_add_en    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: if (START && !STOP) w_state_nxt = ACC;
      ACC: begin
        if (STOP) begin
          w_state_nxt = IDLE;
        end else begin
          w_clear  = 1'b0;
          w_add_en = DATA_VALID;
          w_last   = DATA_VALID && (r_cnt == '1);
          if (w_last && !MODE_CONT) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (w_clear)       r_cnt <= '0;
      else if (w_add_en) r_cnt <= r_cnt + LOG2_SAMPS'(1);
    end
  end

  assign w_samples = DATA_IN;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      adc_avg_channel #(
        .ADC_WIDTH (ADC_WIDTH),
        .LOG2_SAMPS(LOG2_SAMPS),
        .FRAC_BITS (FRAC_BITS)
      ) u_ch (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_clear (w_clear),
        .i_add_en(w_add_en),
        .i_last  (w_last),
        .i_sample(w_samples[c]),
        .o_mean  (w_means[c])
      );
    end
  endgenerate

  assign DATA_OUT = w_means;
  assign BUSY     = (r_state == ACC);
  assign DONE     = r_done;

endmodule

// File: tb/tb_adc_window_average.sv
// Directed bench: one default-size instance (1024-sample window) and one with
// a 4-sample window for rounding, gapping, continuous, STOP and reset cases.
module tb_adc_window_average;

  localparam int OW = 13;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST_N;

  logic [23:0] a_din, b_din;
  logic        a_valid, a_start, a_stop, a_mode;
  logic        b_valid, b_start, b_stop, b_mode;
  logic        a_busy, a_done, b_busy, b_done;
  logic [25:0] a_out, b_out;

  int n_tests = 0;
  int n_fail  = 0;

  adc_window_average #(.ADC_WIDTH(12), .NUM_CH(2), .LOG2_SAMPS(10), .FRAC_BITS(1)) u_a (
    .CLK(CLK), .RST_N(RST_N), .DATA_IN(a_din), .DATA_VALID(a_valid), .START(a_start),
    .STOP(a_stop), .MODE_CONT(a_mode), .BUSY(a_busy), .DONE(a_done), .DATA_OUT(a_out));

  adc_window_average #(.ADC_WIDTH(12), .NUM_CH(2), .LOG2_SAMPS(2), .FRAC_BITS(1)) u_b (
    .CLK(CLK), .RST_N(RST_N), .DATA_IN(b_din), .DATA_VALID(b_valid), .START(b_start),
    .STOP(b_stop), .MODE_CONT(b_mode), .BUSY(b_busy), .DONE(b_done), .DATA_OUT(b_out));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  function automatic logic [31:0] ch(input logic [25:0] d, input int c);
    logic signed [OW-1:0] t;
    t = d[c*OW +: OW];
    return 32'(t);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic setb(input int c0, input int c1, input logic v);
    b_din   = {12'(c1), 12'(c0)};
    b_valid = v;
  endtask

  initial begin
    int  n;
    bit  seen;
    RST_N = 1'b0;
    a_din = '0; a_valid = 0; a_start = 0; a_stop = 0; a_mode = 0;
    b_din = '0; b_valid = 0; b_start = 0; b_stop = 0; b_mode = 0;
    #2;
    chk("rst_a_busy", 32'(a_busy), 0);
    chk("rst_a_done", 32'(a_done), 0);
    chk("rst_a_out",  32'(a_out),  0);
    chk("rst_b_out",  32'(b_out),  0);
    step(); step();
    RST_N = 1'b1;

    // Full-scale constants over a 1024-sample window
    a_din = {12'h800, 12'h7FF}; a_valid = 1; a_start = 1;
    step();
    chk("a_busy_after_start", 32'(a_busy), 1);
    a_start = 0;
    n = 0;
    while (n < 2000) begin
      step();
      n++;
      if (a_done) break;
    end
    chk("a_done_latency", 32'(n), 1024);
    chk("a_ch0_fullscale", ch(a_out, 0), 32'(4094));
    chk("a_ch1_fullscale", ch(a_out, 1), -32'sd4096);
    chk("a_busy_falls",    32'(a_busy), 0);
    step();
    chk("a_done_pulse",    32'(a_done), 0);
    chk("a_busy_oneshot",  32'(a_busy), 0);
    a_valid = 0;

    // Small window, basic rounding
    b_start = 1; step(); b_start = 0;
    setb(1, -1, 1); step();
    setb(2, -1, 1); step();
    setb(2, -1, 1); step();
    chk("b1_no_early_done", 32'(b_done), 0);
    setb(2, -2, 1); step();
    chk("b1_done", 32'(b_done), 1);
    chk("b1_ch0",  ch(b_out, 0), 32'(4));
    chk("b1_ch1",  ch(b_out, 1), -32'sd2);
    chk("b1_busy", 32'(b_busy), 0);
    setb(0, 0, 0); step();
    chk("b1_done_low", 32'(b_done), 0);

    // Gapped strobe; junk on non-strobe cycles; -0.5 rounds up to 0
    b_start = 1; step(); b_start = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      setb(1000, -1000, 0); step(); seen |= b_done;
      setb(1000, -1000, 0); step(); seen |= b_done;
      setb(3 + 2*i, (i == 3) ? -1 : 0, 1); step();
      if (i < 3) seen |= b_done;
    end
    chk("b2_no_early_done", 32'(seen), 0);
    chk("b2_done", 32'(b_done), 1);
    chk("b2_ch0",  ch(b_out, 0), 32'(12));
    chk("b2_ch1",  ch(b_out, 1), 32'(0));
    setb(0, 0, 0); step();
    chk("b2_done_low", 32'(b_done), 0);

    // Continuous ramp, back-to-back windows
    b_mode = 1; b_start = 1; step(); b_start = 0;
    for (int i = 0; i < 12; i++) begin
      setb(i, 0, 1); step();
      if (i % 4 == 3) begin
        chk("b3_done", 32'(b_done), 1);
        chk("b3_ch0",  ch(b_out, 0), 32'(3 + 8*(i/4)));
        chk("b3_busy", 32'(b_busy), 1);
      end else begin
        chk("b3_no_done", 32'(b_done), 0);
      end
    end
    b_stop = 1; setb(50, 50, 1); step();
    b_stop = 0; b_mode = 0;
    chk("b3_stop_busy", 32'(b_busy), 0);
    chk("b3_stop_done", 32'(b_done), 0);

    // STOP mid-window, then a fresh window
    b_start = 1; setb(0, 0, 0); step(); b_start = 0;
    setb(10, 10, 1); step(); step();
    b_stop = 1; step(); b_stop = 0;
    chk("b4_stop_busy", 32'(b_busy), 0);
    chk("b4_stop_done", 32'(b_done), 0);
    chk("b4_hold_ch0",  ch(b_out, 0), 32'(19));
    seen = 0;
    for (int i = 0; i < 4; i++) begin step(); seen |= b_done | b_busy; end
    chk("b4_idle_quiet", 32'(seen), 0);
    b_start = 1; setb(0, 0, 0); step(); b_start = 0;
    for (int i = 0; i < 4; i++) begin setb(1, -3, 1); step(); end
    chk("b4_done", 32'(b_done), 1);
    chk("b4_ch0",  ch(b_out, 0), 32'(2));
    chk("b4_ch1",  ch(b_out, 1), -32'sd6);
    setb(0, 0, 0);

    // START and STOP together from IDLE
    b_start = 1; b_stop = 1; step();
    chk("b5_busy_a", 32'(b_busy), 0);
    b_start = 0; b_stop = 0; step();
    chk("b5_busy_b", 32'(b_busy), 0);

    // Asynchronous reset mid-window
    b_start = 1; step(); b_start = 0;
    setb(100, 100, 1); step(); step();
    chk("b6_busy_pre", 32'(b_busy), 1);
    #3 RST_N = 1'b0;
    #1;
    chk("b6_rst_out",  32'(b_out),  0);
    chk("b6_rst_busy", 32'(b_busy), 0);
    chk("b6_rst_done", 32'(b_done), 0);
    chk("b6_rst_a_out", 32'(a_out), 0);
    step();
    RST_N = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin step(); seen |= b_done | b_busy; end
    chk("b6_quiet_after", 32'(seen), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_window_average.md
# adc_window_average

Multi-channel, parametrised windowed averager for the SPGD ADC front end. It accumulates 2^LOG2_SAMPS signed samples per channel, qualified by a sample strobe, and emits a rounded mean with FRAC_BITS fractional bits. It runs either one-shot (START-triggered) or continuously, with back-to-back windows and no dropped samples. It sits between the ADC capture logic and the SPGD metric/perturbation controller.

## Interface
- ADC_WIDTH, 12: signed two's-complement sample width per channel
- NUM_CH, 2: number of channels averaged in lockstep
- LOG2_SAMPS, 10: window length is 2^LOG2_SAMPS accepted samples; range 1..16
- FRAC_BITS, 1: fractional bits kept in the mean; 0 ≤ FRAC_BITS ≤ LOG2_SAMPS
- CLK  in  1  sole clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- DATA_IN  in  NUM_CH*ADC_WIDTH  channel c in bits [c*ADC_WIDTH +: ADC_WIDTH]
- DATA_VALID  in  1  sample strobe; all channels sampled together
- START  in  1  begin a window (level-sampled, acted on in IDLE only)
- STOP  in  1  abort current window / leave continuous mode
- MODE_CONT  in  1  1 = restart a new window automatically after each DONE
- BUSY  out  1  high while in ACC
- DONE  out  1  one-cycle pulse, DATA_OUT updated on same edge
- DATA_OUT  out  NUM_CH*(ADC_WIDTH+FRAC_BITS)  signed rounded means, channel c in [c*OW +: OW], OW = ADC_WIDTH+FRAC_BITS

## Operation
- Accumulator per channel: signed, ADC_WIDTH+LOG2_SAMPS bits; overflow impossible by construction.
- Sample counter: LOG2_SAMPS bits, counts accepted samples (DATA_VALID in ACC).
- FSM states IDLE, ACC.
  - IDLE: accumulators and counter held at 0. START=1 and STOP=0 → ACC.
  - ACC: each DATA_VALID adds sign-extended sample to each accumulator and increments the counter.
  - Last sample (counter = 2^LOG2_SAMPS−1 and DATA_VALID): DATA_OUT ← round(acc + sample); DONE=1 next cycle; accumulators and counter ← 0. If MODE_CONT=1 stay in ACC, else → IDLE.
  - STOP=1 in ACC: → IDLE, accumulators and counter cleared, no DONE, DATA_OUT holds previous value. A sample with DATA_VALID in the STOP cycle is discarded, even if it is the last one.
- START while in ACC ignored. START and STOP in the same cycle: STOP wins (remain/return IDLE).
- MODE_CONT is sampled only at the window-end edge.
- Rounding: S = LOG2_SAMPS − FRAC_BITS. If S>0, result = (sum + 2^(S−1)) >>> S (round half toward +inf). If S=0, result = sum. The result always fits OW bits signed; no saturation logic.
- DATA_OUT is held between DONE pulses.

## Timing
- Reset (RST_N low, asynchronous): state IDLE, BUSY=0, DONE=0, DATA_OUT=0, accumulators=0, counter=0. Release is synchronised by the user; the block makes no assumption beyond a clean deassertion.
- START at edge t → BUSY=1 after t; first sample acceptable at edge t+1.
- Last sample accepted at edge k → DONE=1 and new DATA_OUT visible in cycle k..k+1 (registered on edge k), DONE low after edge k+1.
- Continuous mode: a sample at edge k+1 is the first sample of the next window (zero gap).
- Minimum window duration 2^LOG2_SAMPS cycles (DATA_VALID tied high).
- Reset mid-window: all state cleared immediately; no DONE.

## Structure
- Package adc_avg_pkg: state enum (IDLE, ACC), width helper functions (acc width, OW, S), parameter legality checks.
- Sub-module adc_avg_channel: one accumulator plus rounding/shift datapath. Inputs are clear, add_en, last and the sample; output is the rounded mean. It is instantiated NUM_CH times by generate. The FSM, counter, DONE and BUSY live in the top.

## Test plan
- Defaults; ch0 constant 2047, ch1 constant −2048, DATA_VALID=1, one-shot → single DONE 1024 cycles after first sample; ch0=4094 (0x0FFE), ch1=−4096 (0x1000); BUSY falls with DONE.
- LOG2_SAMPS=2, FRAC_BITS=1; ch0 samples 1,2,2,2 → 4 (2.0); ch1 samples −1,−1,−1,−2 → −2 (−1.0).
- Gapped DATA_VALID (every 3rd cycle), LOG2_SAMPS=2 → DONE exactly one cycle after the 4th strobe; the non-strobe data values are ignored.
- MODE_CONT=1, LOG2_SAMPS=2, continuous ramp 0,1,2,… on ch0 → DONE every 4 cycles with no gap. Values with FRAC_BITS=1 are 3, 11, 19, …
- STOP asserted after 2 samples → no DONE, BUSY falls, DATA_OUT unchanged. A fresh START then gives a result from only the new samples. START+STOP in the same cycle from IDLE → stays IDLE.
- RST_N pulsed low mid-window (asynchronous, off-edge) → outputs zero immediately; no DONE after release.
